if_fetch: RTL and testbench

Instruction-fetch front end of the 5-stage pipeline: owns the fetch PC, issues single-outstanding requests to instruction memory, and presents {PC, IR, NPC} with a valid flag to the IF/ID pipeline register. It is the producer side of the IF/ID interface: it honours the hazard unit's `stall` and accepts branch/jump redirects from later stages. A one-entry skid buffer absorbs a response that arrives while IF/ID is stalled.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fetch.sv | 165 ++++++++++++++++
 tb/tb_if_fetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e    : fetch FSM encoding (fetch / wait / drain / full)
//   NOP_INSTR        : instruction word injected into the IF/ID slot on a flush
//   RESET_PC_DEFAULT : default first fetch address after reset
package if_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StDrain = 2'd2,
    StFull  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch front end. Owns the fetch PC, issues one outstanding request at a time
// to instruction memory and presents {PC, IR, NPC} plus a valid flag to the IF/ID register.
// A one-entry skid buffer holds a response that returns while IF/ID is stalled.
//
// Ports:
//   clk, reset              : clock (rising edge), asynchronous active-high reset
//   stall                   : IF/ID holds this cycle; the output slot must not change
//   redirect, redirect_pc   : taken branch/jump and its target; flushes the wrong path
//   imem_req, imem_addr     : request valid and address (combinational from state and pc)
//   imem_gnt                : request accepted at this edge
//   imem_rvalid, imem_rdata : response valid and instruction word
//   o_PC, O_IR, O_NPC       : fetched instruction slot to IF/ID
//   o_valid                 : slot holds a live instruction
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] o_PC,
  output logic [31:0] O_IR,
  output logic [31:0] O_NPC,
  output logic        o_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_ir_q, out_ir_d;
  logic [31:0]  out_npc_q, out_npc_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_ir_q, skid_ir_d;

  logic         slot_free;
  logic [31:0]  pc_plus4;
  logic [31:0]  skid_npc;

  assign slot_free = !out_valid_q || !stall;
  assign pc_plus4  = pc_q + 32'd4;
  assign skid_npc  = skid_pc_q + 32'd4;

  // Request is a pure function of state so it stays stable until granted.
  assign imem_req  = (state_q == StFetch) && !reset;
  assign imem_addr = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_ir_d    = out_ir_q;
    out_npc_d   = out_npc_q;
    out_valid_d = out_valid_q;
    skid_pc_d   = skid_pc_q;
    skid_ir_d   = skid_ir_q;

    // Consumed slot goes invalid; a same-edge load below overrides this.
    if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // Request already accepted for the old path: its response must be dropped.
          if (imem_gnt) begin
            state_d = StDrain;
          end
        end else if (imem_gnt) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? StFetch : StDrain;
        end else if (imem_rvalid) begin
          pc_d = pc_plus4;
          if (slot_free) begin
            out_pc_d    = pc_q;
            out_ir_d    = imem_rdata;
            out_npc_d   = pc_plus4;
            out_valid_d = 1'b1;
            state_d     = StFetch;
          end else begin
            skid_pc_d = pc_q;
            skid_ir_d = imem_rdata;
            state_d   = StFull;
          end
        end
      end

      StFull: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if (!stall) begin
          out_pc_d    = skid_pc_q;
          out_ir_d    = skid_ir_q;
          out_npc_d   = skid_npc;
          out_valid_d = 1'b1;
          state_d     = StFetch;
        end
      end

      StDrain: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        // The stale response closes the outstanding request even if a new redirect lands on
        // the same edge; nothing else is outstanding, so waiting longer would deadlock.
        if (imem_rvalid) begin
          state_d = StFetch;
        end
      end

      default: state_d = StFetch;
    endcase

    // Flush wins over stall.
    if (redirect) begin
      out_valid_d = 1'b0;
      out_ir_d    = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      out_pc_q    <= 32'h0;
      out_ir_q    <= 32'h0;
      out_npc_q   <= 32'h0;
      out_valid_q <= 1'b0;
      skid_pc_q   <= 32'h0;
      skid_ir_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_ir_q    <= out_ir_d;
      out_npc_q   <= out_npc_d;
      out_valid_q <= out_valid_d;
      skid_pc_q   <= skid_pc_d;
      skid_ir_q   <= skid_ir_d;
    end
  end

  assign o_PC    = out_pc_q;
  assign O_IR    = out_ir_q;
  assign O_NPC   = out_npc_q;
  assign o_valid = out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eir;
    logic [31:0] enpc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] o_PC;
  logic [31:0] O_IR;
  logic [31:0] O_NPC;
  logic        o_valid;

  int n_chk  = 0;
  int n_pass = 0;

  if_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .o_PC       (o_PC),
    .O_IR       (O_IR),
    .O_NPC      (O_NPC),
    .o_valid    (o_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s.%s got %h expected %h", nm, fld, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic ereq, input logic [31:0] eaddr, input logic ev,
                              input logic [31:0] epc, input logic [31:0] eir,
                              input logic [31:0] enpc);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc; v.eir = eir; v.enpc = enpc;
    return v;
  endfunction

  // Called just after a falling edge: drive one cycle, check request, then check the slot
  // just after the rising edge, and return at the next falling edge.
  task automatic step(input string nm, input vec_t v);
    stall       = v.st;
    redirect    = v.rd;
    redirect_pc = v.rpc;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    #1;
    chk(nm, "imem_req", {31'b0, imem_req}, {31'b0, v.ereq});
    if (v.ereq) chk(nm, "imem_addr", imem_addr, v.eaddr);
    @(posedge clk);
    #1;
    chk(nm, "o_valid", {31'b0, o_valid}, {31'b0, v.ev});
    chk(nm, "o_PC", o_PC, v.epc);
    chk(nm, "O_IR", O_IR, v.eir);
    chk(nm, "O_NPC", O_NPC, v.enpc);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, "imem_req", {31'b0, imem_req}, 32'h0);
    chk(nm, "o_valid", {31'b0, o_valid}, 32'h0);
    chk(nm, "o_PC", o_PC, 32'h0);
    chk(nm, "O_IR", O_IR, 32'h0);
    chk(nm, "O_NPC", O_NPC, 32'h0);
  endtask

  vec_t tbl[25];

  initial begin
    //             st rd rpc           gnt rv rdata         req addr          v  pc            ir            npc
    tbl[0]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h4);
    tbl[2]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0,        32'h4);
    tbl[3]  = mk(0, 0, 32'h0,        0, 1, 32'h4,        0, 32'h0,        1, 32'h4,        32'h4,        32'h8);
    tbl[4]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h4,        32'h8);
    tbl[5]  = mk(1, 0, 32'h0,        0, 1, 32'hDEAD_0008, 0, 32'h0,       1, 32'h4,        32'h4,        32'h8);
    tbl[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h4,        32'h8);
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hDEAD_0008, 32'hC);
    tbl[8]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hC,        0, 32'h8,        32'hDEAD_0008, 32'hC);
    tbl[9]  = mk(0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h0,        32'hC);
    tbl[10] = mk(0, 0, 32'h0,        0, 1, 32'hBAD0_000C, 0, 32'h0,       0, 32'h8,        32'h0,        32'hC);
    tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'h8,        32'h0,        32'hC);
    tbl[12] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      0, 32'h8,        32'h0,        32'hC);
    tbl[13] = mk(0, 0, 32'h0,        0, 1, 32'h1100,     0, 32'h0,        1, 32'h100,      32'h1100,     32'h104);
    tbl[14] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'h1100,     32'h104);
    tbl[15] = mk(1, 1, 32'h100,      0, 1, 32'hBAD1,     0, 32'h0,        0, 32'h100,      32'h0,        32'h104);
    tbl[16] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'h100,      32'h0,        32'h104);
    tbl[17] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       1, 32'h100,      0, 32'h100,      32'h0,        32'h104);
    tbl[18] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h100,     32'h0,        32'h104);
    tbl[19] = mk(0, 0, 32'h0,        0, 1, 32'h1234_5678, 0, 32'h0,       1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0);
    tbl[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0);
    tbl[21] = mk(0, 1, 32'h40,       1, 0, 32'h0,        1, 32'h0,        0, 32'hFFFF_FFFC, 32'h0,      32'h0);
    tbl[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0,      32'h0);
    tbl[23] = mk(0, 0, 32'h0,        0, 1, 32'hBAD2,     0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0,      32'h0);
    tbl[24] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h40,       0, 32'hFFFF_FFFC, 32'h0,      32'h0);

    reset = 1'b1;
    idle_inputs();
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Rows 0-8: zero-wait stream, then a 3-cycle stall absorbed by the skid buffer.
    // Rows 9-12: redirect in WAIT drains the stale response.
    // Rows 13-16: redirect with rvalid under stall. Rows 17-20: pc wrap.
    // Rows 21-24: redirect coincident with grant.
    for (int i = 0; i < 25; i++) begin
      step($sformatf("row%0d", i), tbl[i]);
    end

    // Redirect while the skid buffer is full drops it.
    step("full_a0", mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h40, 0, 32'hFFFF_FFFC, 32'h0, 32'h0));
    step("full_a1", mk(0, 0, 32'h0, 0, 1, 32'hAAAA_0040, 0, 32'h0, 1, 32'h40, 32'hAAAA_0040, 32'h44));
    step("full_a2", mk(1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h44, 1, 32'h40, 32'hAAAA_0040, 32'h44));
    step("full_a3", mk(1, 0, 32'h0, 0, 1, 32'hBBBB_0044, 0, 32'h0, 1, 32'h40, 32'hAAAA_0040, 32'h44));
    step("full_a4", mk(1, 1, 32'h80, 0, 0, 32'h0, 0, 32'h0, 0, 32'h40, 32'h0, 32'h44));
    step("full_a5", mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h80, 0, 32'h40, 32'h0, 32'h44));

    // Reset asserted while in FULL.
    step("rst_b0", mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h80, 0, 32'h40, 32'h0, 32'h44));
    step("rst_b1", mk(0, 0, 32'h0, 0, 1, 32'hC0, 0, 32'h0, 1, 32'h80, 32'hC0, 32'h84));
    step("rst_b2", mk(1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h84, 1, 32'h80, 32'hC0, 32'h84));
    step("rst_b3", mk(1, 0, 32'h0, 0, 1, 32'hC4, 0, 32'h0, 1, 32'h80, 32'hC0, 32'h84));
    idle_inputs();
    stall = 1'b1;
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release", "imem_req", {31'b0, imem_req}, 32'h1);
    chk("rst_release", "imem_addr", imem_addr, 32'h0);
    step("rst_b4", mk(0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0, 32'h0));
    step("rst_b5", mk(0, 0, 32'h0, 0, 1, 32'h5A5A, 0, 32'h0, 1, 32'h0, 32'h5A5A, 32'h4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
